// File: rtl/rst_seq_sync.sv
// Reset synchroniser and release sequencer: synchronises deassertion of the
// external active-low reset, then releases NUM_CH active-low channel resets
// in ascending order with GAP_CYC cycles between them. A single-cycle
// SW_RST_REQ in the all-released state replays the sequence after HOLD_CYC.
module rst_seq_sync #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned GAP_CYC    = 4,
  parameter int unsigned HOLD_CYC   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW_RST_REQ,
  output logic [NUM_CH-1:0] RST_SYNC,
  output logic              RST_DONE
);

  localparam int unsigned MAX_CYC = (GAP_CYC > HOLD_CYC) ? GAP_CYC : HOLD_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;
  localparam int unsigned IW      = $clog2(NUM_CH) + 1;

  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [IW-1:0] LAST_CH   = IW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    WAIT_SYNC,
    RELEASE,
    DONE,
    HOLD
  } state_t;

  logic [NUM_STAGES-1:0] sync_q;
  logic                  sync_ok;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_CH-1:0]     rst_sync_q, rst_sync_d;
  logic                  done_q, done_d;
  logic                  kick;

  assign sync_ok = sync_q[NUM_STAGES-1];

  // Deassertion synchroniser: shifts in ones once the external reset is released.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], 1'b1};
    end
  end

  // Sequencer state, counters and reset outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= WAIT_SYNC;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_sync_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_sync_q <= rst_sync_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; the channel-0 release common to WAIT_SYNC and HOLD exit
  // is folded into a single kick path after the state decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_sync_d = rst_sync_q;
    done_d     = done_q;
    kick       = 1'b0;

    unique case (state_q)
      WAIT_SYNC: begin
        if (sync_ok) begin
          kick = 1'b1;
        end
      end
      RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (idx_q == IW'(i)) begin
              rst_sync_d[i] = 1'b1;
            end
          end
          idx_d = idx_q + IW'(1);
          cnt_d = '0;
          if (idx_q == LAST_CH) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (SW_RST_REQ) begin
          rst_sync_d = '0;
          done_d     = 1'b0;
          cnt_d      = '0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          kick = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = WAIT_SYNC;
      end
    endcase

    if (kick) begin
      rst_sync_d[0] = 1'b1;
      idx_d         = IW'(1);
      cnt_d         = '0;
      if (NUM_CH == 1) begin
        done_d  = 1'b1;
        state_d = DONE;
      end else begin
        state_d = RELEASE;
      end
    end
  end

  assign RST_SYNC = rst_sync_q;
  assign RST_DONE = done_q;

endmodule

// File: tb/tb_rst_seq_sync.sv
// Bench for rst_seq_sync: three parameterisations share stimulus; each is
// checked against a release-time model (channel count = f(edge, base edge)).
module tb_rst_seq_sync;

  logic       CLK;
  logic       RST;
  logic       SW;
  logic [2:0] s0;
  logic       d0;
  logic [0:0] s1;
  logic       d1;
  logic [3:0] s2;
  logic       d2;

  rst_seq_sync #(.NUM_STAGES(2), .NUM_CH(3), .GAP_CYC(4), .HOLD_CYC(4)) u0 (
    .CLK(CLK), .RST(RST), .SW_RST_REQ(SW), .RST_SYNC(s0), .RST_DONE(d0));
  rst_seq_sync #(.NUM_STAGES(3), .NUM_CH(1), .GAP_CYC(1), .HOLD_CYC(4)) u1 (
    .CLK(CLK), .RST(RST), .SW_RST_REQ(SW), .RST_SYNC(s1), .RST_DONE(d1));
  rst_seq_sync #(.NUM_STAGES(2), .NUM_CH(4), .GAP_CYC(1), .HOLD_CYC(2)) u2 (
    .CLK(CLK), .RST(RST), .SW_RST_REQ(SW), .RST_SYNC(s2), .RST_DONE(d2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model parameters per instance
  int NS [3] = '{2, 3, 2};
  int NC [3] = '{3, 1, 4};
  int GP [3] = '{4, 1, 1};
  int HD [3] = '{4, 4, 2};

  // Model state: absolute edge count, edge at which channel 0 releases
  int base [3];
  int nabs   = 0;
  bit in_rst = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  function automatic int rel(int k, int n);
    int r;
    if (in_rst || n < base[k]) return 0;
    r = 1 + (n - base[k]) / GP[k];
    if (r > NC[k]) r = NC[k];
    return r;
  endfunction

  task automatic cmp(string tag, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_rst(logic v);
    RST = v;
    if (!v) begin
      in_rst = 1'b1;
    end else if (in_rst) begin
      in_rst = 1'b0;
      for (int k = 0; k < 3; k++) base[k] = nabs + NS[k] + 1;
    end
  endtask

  task automatic check_all();
    int act_s, act_d, r;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin act_s = int'(s0); act_d = int'(d0); end
        1:       begin act_s = int'(s1); act_d = int'(d1); end
        default: begin act_s = int'(s2); act_d = int'(d2); end
      endcase
      r = rel(k, nabs);
      cmp($sformatf("dut%0d sync edge%0d", k, nabs), act_s, (1 << r) - 1);
      cmp($sformatf("dut%0d done edge%0d", k, nabs), act_d, (r == NC[k]) ? 1 : 0);
    end
  endtask

  // One clock: model update on the rising edge, comparison on the falling edge
  task automatic tick();
    @(posedge CLK);
    for (int k = 0; k < 3; k++) begin
      if (!in_rst && SW && rel(k, nabs) == NC[k]) base[k] = nabs + 1 + HD[k];
    end
    nabs++;
    @(negedge CLK);
    check_all();
  endtask

  task automatic chk0(string tag, logic [2:0] es, logic ed);
    cmp({tag, " u0 sync"}, int'(s0), int'(es));
    cmp({tag, " u0 done"}, int'(d0), int'(ed));
  endtask

  typedef struct {
    logic       sw;
    logic [2:0] s0;
    logic       d0;
    logic       s1;
    logic [3:0] s2;
    logic       d2;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int r;
    tbl[0]  = '{1'b0, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[2]  = '{1'b0, 3'b001, 1'b0, 1'b0, 4'b0001, 1'b0};
    tbl[3]  = '{1'b0, 3'b001, 1'b0, 1'b1, 4'b0011, 1'b0};
    tbl[4]  = '{1'b1, 3'b001, 1'b0, 1'b0, 4'b0111, 1'b0};
    tbl[5]  = '{1'b0, 3'b001, 1'b0, 1'b0, 4'b1111, 1'b1};
    tbl[6]  = '{1'b0, 3'b011, 1'b0, 1'b0, 4'b1111, 1'b1};
    tbl[7]  = '{1'b0, 3'b011, 1'b0, 1'b0, 4'b1111, 1'b1};
    tbl[8]  = '{1'b0, 3'b011, 1'b0, 1'b1, 4'b1111, 1'b1};
    tbl[9]  = '{1'b0, 3'b011, 1'b0, 1'b1, 4'b1111, 1'b1};
    tbl[10] = '{1'b1 & 1'b0, 3'b111, 1'b1, 1'b1, 4'b1111, 1'b1};

    RST = 1'b1;
    SW  = 1'b0;
    #1;
    set_rst(1'b0);
    #1;
    check_all();
    chk0("reset", 3'b000, 1'b0);
    tick();
    tick();

    // Power-up sequence from the vector table (row i = edge i+1)
    set_rst(1'b1);
    for (int i = 0; i < 11; i++) begin
      SW = tbl[i].sw;
      tick();
      SW = 1'b0;
      chk0($sformatf("pwr e%0d", i + 1), tbl[i].s0, tbl[i].d0);
      cmp($sformatf("pwr e%0d u1 sync", i + 1), int'(s1), int'(tbl[i].s1));
      cmp($sformatf("pwr e%0d u1 done", i + 1), int'(d1), int'(tbl[i].s1));
      cmp($sformatf("pwr e%0d u2 sync", i + 1), int'(s2), int'(tbl[i].s2));
      cmp($sformatf("pwr e%0d u2 done", i + 1), int'(d2), int'(tbl[i].d2));
    end

    // Warm reset at edge e, with an ignored request during HOLD at e+2
    tick();
    SW = 1'b1;
    tick();
    SW = 1'b0;
    chk0("warm e", 3'b000, 1'b0);
    for (int j = 1; j <= 12; j++) begin
      SW = (j == 2);
      tick();
      SW = 1'b0;
      case (j)
        3:  chk0("warm e+3", 3'b000, 1'b0);
        4:  chk0("warm e+4", 3'b001, 1'b0);
        7:  chk0("warm e+7", 3'b001, 1'b0);
        8:  chk0("warm e+8", 3'b011, 1'b0);
        11: chk0("warm e+11", 3'b011, 1'b0);
        12: chk0("warm e+12", 3'b111, 1'b1);
        default: ;
      endcase
    end

    // Asynchronous assertion at edge 8 of a fresh sequence
    set_rst(1'b0);
    tick();
    set_rst(1'b1);
    for (int j = 1; j <= 8; j++) tick();
    chk0("async pre", 3'b011, 1'b0);
    set_rst(1'b0);
    #1;
    chk0("async now", 3'b000, 1'b0);
    check_all();
    tick();
    tick();
    set_rst(1'b1);
    for (int j = 1; j <= 11; j++) begin
      tick();
      case (j)
        2:  chk0("re e2", 3'b000, 1'b0);
        3:  chk0("re e3", 3'b001, 1'b0);
        7:  chk0("re e7", 3'b011, 1'b0);
        10: chk0("re e10", 3'b011, 1'b0);
        11: chk0("re e11", 3'b111, 1'b1);
        default: ;
      endcase
    end

    // Request and reset assertion together while in DONE
    SW = 1'b1;
    set_rst(1'b0);
    #1;
    chk0("simul now", 3'b000, 1'b0);
    check_all();
    tick();
    SW = 1'b0;
    set_rst(1'b1);
    for (int j = 1; j <= 11; j++) begin
      tick();
      case (j)
        3:  chk0("simul e3", 3'b001, 1'b0);
        4:  cmp("simul e4 u1 sync", int'(s1), 1);
        7:  chk0("simul e7", 3'b011, 1'b0);
        11: chk0("simul e11", 3'b111, 1'b1);
        default: ;
      endcase
    end

    // Sub-cycle glitch mid-sequence
    set_rst(1'b0);
    tick();
    set_rst(1'b1);
    for (int j = 1; j <= 5; j++) tick();
    set_rst(1'b0);
    #1;
    chk0("glitch low", 3'b000, 1'b0);
    #1;
    set_rst(1'b1);
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 3) chk0("glitch e3", 3'b001, 1'b0);
    end

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      SW = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        set_rst(1'b0);
        #1;
        check_all();
        #1;
        set_rst(1'b1);
      end else if (r < 3) begin
        set_rst(1'b0);
        #1;
        check_all();
        for (int h = 0; h < int'($urandom_range(1, 3)); h++) tick();
        set_rst(1'b1);
      end
      tick();
    end
    SW = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
